// File: rtl/cam_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// cam_cfg_sequencer
//
// Walks a {reg,val} camera init table stored in an external ROM and issues one
// register-write request per entry to the SCCB master. Two in-band markers are
// understood: an all-ones entry ends the table, and an all-ones register with
// value F0 inserts a fixed wait instead of a write. Progress is reported
// through o_busy / o_done / o_entry_cnt, and failures through a sticky o_err.
//
// Optional feature macro: CAM_CFG_RETRY_EN
//   defined   : a NACKed write is re-issued up to MAX_RETRY times per entry
//   undefined : the first NACK aborts the run with o_err
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_start      1-cycle pulse, runs the table from address 0 (ignored if busy)
//   o_rom_addr   ROM address
//   i_rom_data   ROM data, valid ROM_LAT cycles after o_rom_addr
//   o_wr_valid   write request valid
//   i_wr_ready   SCCB master accepts the request
//   o_wr_reg     register address of the request
//   o_wr_val     register value of the request
//   i_wr_done    1-cycle pulse, transaction finished
//   i_wr_nack    qualified by i_wr_done, slave NACKed
//   o_busy       sequence in progress
//   o_done       1-cycle pulse, end marker reached without error
//   o_err        sticky error, cleared by i_start or i_rst
//   o_entry_cnt  writes completed in the current run
// -----------------------------------------------------------------------------
module cam_cfg_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int REG_W        = 8,
  parameter int VAL_W        = 8,
  parameter int ROM_LAT      = 1,
  parameter int DELAY_CYCLES = 270000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic [ADDR_W-1:0]      o_rom_addr,
  input  logic [REG_W+VAL_W-1:0] i_rom_data,
  output logic                   o_wr_valid,
  input  logic                   i_wr_ready,
  output logic [REG_W-1:0]       o_wr_reg,
  output logic [VAL_W-1:0]       o_wr_val,
  input  logic                   i_wr_done,
  input  logic                   i_wr_nack,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [ADDR_W-1:0]      o_entry_cnt
);

  localparam int DATA_W = REG_W + VAL_W;
  localparam int DLY_W  = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DATA_W-1:0] END_MARK   = '1;
  localparam logic [DATA_W-1:0] DELAY_MARK = {{REG_W{1'b1}}, VAL_W'(8'hF0)};

`ifdef CAM_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // With retries disabled the limit collapses to zero, so the same NACK path
  // serves both builds and the first NACK goes straight to ERROR.
  localparam int RETRY_LIMIT = RETRY_EN ? MAX_RETRY : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic               lat_q, lat_d;
  logic               advance;
  logic               fail;

  // State register plus every registered output; reset is synchronous so a
  // request that is pending in ISSUE is withdrawn at the reset edge itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      retry_q <= '0;
      delay_q <= '0;
      lat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      delay_q <= delay_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic. States compute 'advance' (move to the next entry) and
  // 'fail' (abort the run); those are applied after the case so the wrap
  // check and the error bookkeeping live in exactly one place.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    reg_d   = reg_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    delay_d = delay_q;
    lat_d   = lat_q;
    advance = 1'b0;
    fail    = 1'b0;

    case (state_q)
      // DONE and ERROR last one cycle with o_busy already low, so a start
      // arriving there is honoured just like one arriving in IDLE.
      S_IDLE, S_DONE, S_ERROR: begin
        state_d = S_IDLE;
        if (i_start) begin
          addr_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          lat_d   = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (int'(lat_q) == ROM_LAT - 1) begin
          state_d = S_DECODE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (i_rom_data == END_MARK) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (i_rom_data == DELAY_MARK) begin
          delay_d = '0;
          state_d = S_DELAY;
        end else begin
          reg_d   = i_rom_data[DATA_W-1:VAL_W];
          val_d   = i_rom_data[VAL_W-1:0];
          valid_d = 1'b1;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (i_wr_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_wr_done) begin
          if (!i_wr_nack) begin
            cnt_d   = cnt_q + 1'b1;
            advance = 1'b1;
          end else if (int'(retry_q) < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            fail = 1'b1;
          end
        end
      end

      S_DELAY: begin
        if (int'(delay_q) == DELAY_CYCLES - 1) begin
          advance = 1'b1;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Running off the last ROM address means the table has no end marker;
    // treat that as an error instead of wrapping back to entry 0.
    if (advance) begin
      if (addr_q == '1) begin
        fail = 1'b1;
      end else begin
        addr_d  = addr_q + 1'b1;
        lat_d   = 1'b0;
        state_d = S_FETCH;
      end
    end

    if (fail) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = S_ERROR;
    end
  end

  assign o_rom_addr  = addr_q;
  assign o_wr_valid  = valid_q;
  assign o_wr_reg    = reg_q;
  assign o_wr_val    = val_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_entry_cnt = cnt_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cam_cfg_sequencer
//
// Scoreboard bench for cam_cfg_sequencer. The main process loads small init
// tables into a ROM model and pushes the writes each table should produce; a
// monitor pops and compares on every accepted request. A simple SCCB slave
// model answers requests with configurable ready/done delays and NACKs.
// Honors CAM_CFG_RETRY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_cam_cfg_sequencer;

  localparam int ADDR_W       = 3;
  localparam int REG_W        = 8;
  localparam int VAL_W        = 8;
  localparam int ROM_LAT      = 2;
  localparam int DELAY_CYCLES = 20;
  localparam int MAX_RETRY    = 3;
  localparam int BUDGET       = 600;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_reg;
  logic [7:0]        wr_val;
  logic              wr_done;
  logic              wr_nack;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] entry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  int          rise_q[$];
  int          wrdone_q[$];
  int          accept_cnt  = 0;
  int          done_pulses = 0;
  int          held_cnt    = 0;
  int          cyc         = 0;

  int ready_delay = 3;
  int done_delay  = 3;
  int nack_left   = 0;

  logic [15:0] rom_mem [8];
  logic [15:0] rom_p1, rom_p2;

  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_payload = '0;
  logic [15:0] exp_word;
  int          s_phase = 0;
  int          s_cnt   = 0;

  cam_cfg_sequencer #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .VAL_W(VAL_W), .ROM_LAT(ROM_LAT),
    .DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_reg(wr_reg), .o_wr_val(wr_val),
    .i_wr_done(wr_done), .i_wr_nack(wr_nack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_entry_cnt(entry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM model with a two-stage output pipeline for ROM_LAT = 2.
  always @(posedge clk) begin
    rom_p1 <= rom_mem[rom_addr];
    rom_p2 <= rom_p1;
  end
  assign rom_data = (ROM_LAT == 2) ? rom_p2 : rom_p1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual >= lo && actual <= hi) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  task automatic clearRom();
    for (int i = 0; i < 8; i++) rom_mem[i] = 16'h0000;
  endtask

  task automatic pulseStart();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput(name, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input string name);
    pulseStart();
    waitIdle(name);
  endtask

  // SCCB slave model: holds ready low for ready_delay cycles of valid, then
  // takes the request and reports done (optionally NACK) done_delay cycles later.
  initial begin
    wr_ready = 1'b0;
    wr_done  = 1'b0;
    wr_nack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (rst) begin
        wr_ready = 1'b0;
        s_phase  = 0;
        s_cnt    = 0;
      end else begin
        case (s_phase)
          0: begin
            wr_ready = 1'b0;
            if (wr_valid) begin
              if (s_cnt >= ready_delay) begin
                wr_ready = 1'b1;
                s_phase  = 1;
              end else s_cnt++;
            end else s_cnt = 0;
          end
          1: begin
            wr_ready = 1'b0;
            s_cnt    = 0;
            s_phase  = 2;
          end
          default: begin
            if (s_cnt >= done_delay) begin
              wr_done = 1'b1;
              wr_nack = (nack_left > 0);
              if (nack_left > 0) nack_left--;
              s_phase = 0;
              s_cnt   = 0;
            end else s_cnt++;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted request, checks that a
  // stalled request stays stable, and logs timing of valid rises and dones.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (prev_stall) begin
          held_cnt++;
          checkOutput("valid_held", wr_valid, 1'b1);
          checkOutput("payload_held", {wr_reg, wr_val}, prev_payload);
        end
        if (wr_valid && wr_ready) begin
          accept_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_write: got %h_%h, expected no write", wr_reg, wr_val);
          end else begin
            exp_word = exp_q.pop_front();
            checkOutput("write_payload", {wr_reg, wr_val}, exp_word);
          end
        end
        if (wr_valid && !prev_valid) rise_q.push_back(cyc);
        if (wr_done) wrdone_q.push_back(cyc);
        if (done) done_pulses++;
      end
      prev_stall   = wr_valid && !wr_ready && !rst;
      prev_valid   = wr_valid;
      prev_payload = {wr_reg, wr_val};
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, d0, h0, gap;
    rst   = 1'b1;
    start = 1'b0;
    clearRom();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_rom_addr", rom_addr, 0);
    checkOutput("rst_wr_valid", wr_valid, 0);
    checkOutput("rst_wr_reg", wr_reg, 0);
    checkOutput("rst_wr_val", wr_val, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_entry_cnt", entry_cnt, 0);

    $display("[TB] NACK handling on 40_D0");
    clearRom();
    rom_mem[0] = 16'h40D0; rom_mem[1] = 16'hFFFF;
    nack_left = 2; ready_delay = 3; done_delay = 3;
    a0 = accept_cnt; d0 = done_pulses;
`ifdef CAM_CFG_RETRY_EN
    repeat (3) exp_q.push_back(16'h40D0);
    applyStimulus("t4_idle");
    checkOutput("t4_issues", accept_cnt - a0, 3);
    checkOutput("t4_done", done_pulses - d0, 1);
    checkOutput("t4_err", err, 0);
    checkOutput("t4_cnt", entry_cnt, 1);
`else
    exp_q.push_back(16'h40D0);
    applyStimulus("t4_idle");
    checkOutput("t4_issues", accept_cnt - a0, 1);
    checkOutput("t4_done", done_pulses - d0, 0);
    checkOutput("t4_err", err, 1);
    checkOutput("t4_cnt", entry_cnt, 0);
`endif
    checkOutput("t4_queue_empty", exp_q.size(), 0);
    nack_left = 0;

    $display("[TB] basic table");
    clearRom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1204; rom_mem[2] = 16'h1100; rom_mem[3] = 16'hFFFF;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204); exp_q.push_back(16'h1100);
    a0 = accept_cnt; d0 = done_pulses;
    applyStimulus("t1_idle");
    checkOutput("t1_writes", accept_cnt - a0, 3);
    checkOutput("t1_done", done_pulses - d0, 1);
    checkOutput("t1_cnt", entry_cnt, 3);
    checkOutput("t1_err", err, 0);
    checkOutput("t1_queue_empty", exp_q.size(), 0);

    $display("[TB] delay marker");
    clearRom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204; rom_mem[3] = 16'hFFFF;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    rise_q.delete(); wrdone_q.delete();
    a0 = accept_cnt; d0 = done_pulses;
    applyStimulus("t2_idle");
    gap = (rise_q.size() > 1 && wrdone_q.size() > 0) ? rise_q[1] - wrdone_q[0] : -1;
    checkRange("t2_delay_gap", gap, DELAY_CYCLES, DELAY_CYCLES + 20);
    checkOutput("t2_writes", accept_cnt - a0, 2);
    checkOutput("t2_cnt", entry_cnt, 2);
    checkOutput("t2_done", done_pulses - d0, 1);

    $display("[TB] ready stall");
    clearRom();
    rom_mem[0] = 16'h8C02; rom_mem[1] = 16'hFFFF;
    exp_q.push_back(16'h8C02);
    ready_delay = 10;
    a0 = accept_cnt; h0 = held_cnt;
    applyStimulus("t3_idle");
    checkOutput("t3_writes", accept_cnt - a0, 1);
    checkOutput("t3_held_cycles", held_cnt - h0, 10);
    checkOutput("t3_cnt", entry_cnt, 1);
    ready_delay = 3;

    $display("[TB] missing end marker");
    clearRom();
    for (int i = 0; i < 7; i++) begin
      rom_mem[i] = {8'(8'h01 + i), 8'(8'h10 + i)};
      exp_q.push_back(rom_mem[i]);
    end
    rom_mem[7] = 16'hFFF0;
    ready_delay = 0; done_delay = 1;
    a0 = accept_cnt; d0 = done_pulses;
    applyStimulus("t5_idle");
    repeat (20) @(negedge clk);
    checkOutput("t5_err", err, 1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_writes", accept_cnt - a0, 7);
    checkOutput("t5_cnt", entry_cnt, 7);
    checkOutput("t5_done", done_pulses - d0, 0);
    checkOutput("t5_addr", rom_addr, 7);

    $display("[TB] reset during issue");
    clearRom();
    rom_mem[0] = 16'h3A04; rom_mem[1] = 16'h1280; rom_mem[2] = 16'hFFFF;
    ready_delay = 30; done_delay = 3;
    a0 = accept_cnt;
    pulseStart();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_valid) break;
    end
    checkOutput("t6_valid_before_reset", wr_valid, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_valid", wr_valid, 0);
    checkOutput("t6_rst_reg", wr_reg, 0);
    checkOutput("t6_rst_val", wr_val, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_addr", rom_addr, 0);
    checkOutput("t6_rst_cnt", entry_cnt, 0);
    checkOutput("t6_rst_err", err, 0);
    checkOutput("t6_no_accept", accept_cnt - a0, 0);

    ready_delay = 1;
    exp_q.push_back(16'h3A04); exp_q.push_back(16'h1280);
    a0 = accept_cnt; d0 = done_pulses;
    pulseStart();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (accept_cnt != a0) break;
    end
    checkOutput("t6_first_accept", accept_cnt - a0, 1);
    pulseStart();
    waitIdle("t6_idle");
    checkOutput("t6_writes", accept_cnt - a0, 2);
    checkOutput("t6_cnt", entry_cnt, 2);
    checkOutput("t6_done", done_pulses - d0, 1);
    checkOutput("t6_err", err, 0);
    checkOutput("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
